// File: rtl/kd_tree_root_ctrl.sv
// Bring-up sequencer above the kd-tree root: reset, center fill, sort-axis config.
// Optional per-phase watchdog enabled by defining KD_ROOT_CTRL_TIMEOUT_EN.
module kd_tree_root_ctrl #(
  parameter int DATA_W      = 24,
  parameter int CMD_W       = 5,
  parameter int NUM_CENTERS = 7,
  parameter int CNT_W       = 4,
  parameter int TIMEOUT     = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        sort_axis,
  input  logic [DATA_W-1:0] center_data,
  input  logic              center_valid,
  output logic              center_ready,
  output logic [CMD_W-1:0]  cmd_to_root,
  output logic [DATA_W-1:0] data_to_root,
  input  logic [CMD_W-1:0]  cmd_from_root,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [CNT_W-1:0]  fill_count
);

  localparam logic [CMD_W-1:0] CMD_NOP       = CMD_W'(5'b00000);
  localparam logic [CMD_W-1:0] CMD_RST       = CMD_W'(5'b11111);
  localparam logic [CMD_W-1:0] CMD_RST_DONE  = CMD_W'(5'b11110);
  localparam logic [CMD_W-1:0] CMD_FILL      = CMD_W'(5'b00001);
  localparam logic [CMD_W-1:0] CMD_FILL_DONE = CMD_W'(5'b00101);
  localparam logic [CMD_W-1:0] CMD_AXIS      = CMD_W'(5'b00010);
  localparam logic [CMD_W-1:0] CMD_AXIS_DONE = CMD_W'(5'b00111);
  localparam logic [CNT_W-1:0] FILL_TARGET   = CNT_W'(NUM_CENTERS);

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_FILL, S_AXIS, S_DONE, S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [1:0]        err_q, err_d;
  logic [CNT_W-1:0]  fill_q, fill_d;
  logic [1:0]        axis_q, axis_d;
  logic              handshake;

  assign center_ready = (state_q == S_FILL) && (fill_q < FILL_TARGET);
  assign handshake    = center_ready && center_valid;

`ifdef KD_ROOT_CTRL_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_expired;
  assign tmo_expired = (tmo_q == TMO_W'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT);
`endif

  always_comb begin
    state_d = state_q;
    cmd_d   = CMD_NOP;
    data_d  = '0;
    done_d  = 1'b0;
    err_d   = err_q;
    fill_d  = fill_q;
    axis_d  = axis_q;

    unique case (state_q)
      S_RST: begin
        if (cmd_from_root == CMD_RST_DONE) begin
          state_d = S_FILL;
        end else begin
          cmd_d = CMD_RST;
        end
      end
      S_FILL: begin
        if (handshake) begin
          fill_d = fill_q + 1'b1;
          cmd_d  = CMD_FILL;
          data_d = center_data;
        end else if (fill_q == FILL_TARGET) begin
          cmd_d = CMD_FILL;
        end
        if (cmd_from_root == CMD_FILL_DONE) begin
          if (fill_q < FILL_TARGET) begin
            state_d = S_ERR;
            err_d   = 2'd1;
            cmd_d   = CMD_NOP;
            data_d  = '0;
          end else begin
            state_d = S_AXIS;
            cmd_d   = CMD_AXIS;
            data_d  = DATA_W'(axis_q);
          end
        end
      end
      S_AXIS: begin
        if (cmd_from_root == CMD_AXIS_DONE) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          cmd_d  = CMD_AXIS;
          data_d = DATA_W'(axis_q);
        end
      end
      default: begin
        if (start) begin
          state_d = S_RST;
          cmd_d   = CMD_RST;
          err_d   = 2'd0;
          fill_d  = '0;
          axis_d  = sort_axis;
        end
      end
    endcase

`ifdef KD_ROOT_CTRL_TIMEOUT_EN
    // A completion code already moved the state this cycle, so it beats the watchdog.
    tmo_d = (state_d != state_q) ? '0 : tmo_q + 1'b1;
    if ((state_q == S_RST || state_q == S_FILL || state_q == S_AXIS) &&
        state_d == state_q && tmo_expired) begin
      state_d = S_ERR;
      err_d   = 2'd2;
      cmd_d   = CMD_NOP;
      data_d  = '0;
    end
`endif

    busy_d  = (state_d == S_RST) || (state_d == S_FILL) || (state_d == S_AXIS);
    error_d = (state_d == S_ERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cmd_q   <= CMD_NOP;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      err_q   <= 2'd0;
      fill_q  <= '0;
      axis_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      err_q   <= err_d;
      fill_q  <= fill_d;
      axis_q  <= axis_d;
    end
  end

`ifdef KD_ROOT_CTRL_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  assign cmd_to_root  = cmd_q;
  assign data_to_root = data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign err_code     = err_q;
  assign fill_count   = fill_q;

endmodule

// File: tb/tb_kd_tree_root_ctrl.sv
// Directed bench for kd_tree_root_ctrl; the root side is driven by hand-timed steps.
module tb_kd_tree_root_ctrl;

  localparam logic [4:0] NOP       = 5'b00000;
  localparam logic [4:0] RSTC      = 5'b11111;
  localparam logic [4:0] RST_DONE  = 5'b11110;
  localparam logic [4:0] FILL      = 5'b00001;
  localparam logic [4:0] FILL_DONE = 5'b00101;
  localparam logic [4:0] AXIS      = 5'b00010;
  localparam logic [4:0] AXIS_DONE = 5'b00111;

  logic        clk, rst, start, center_valid, center_ready;
  logic [1:0]  sort_axis, err_code;
  logic [23:0] center_data, data_to_root;
  logic [4:0]  cmd_to_root, cmd_from_root;
  logic        busy, done, error;
  logic [3:0]  fill_count;

  int n_tests = 0;
  int n_fail  = 0;

  kd_tree_root_ctrl #(
    .DATA_W(24), .CMD_W(5), .NUM_CENTERS(7), .CNT_W(4), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .sort_axis(sort_axis),
    .center_data(center_data), .center_valid(center_valid), .center_ready(center_ready),
    .cmd_to_root(cmd_to_root), .data_to_root(data_to_root), .cmd_from_root(cmd_from_root),
    .busy(busy), .done(done), .error(error), .err_code(err_code), .fill_count(fill_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] axis);
    sort_axis = axis;
    start = 1'b1;
    tick();
    start = 1'b0;
    sort_axis = 2'd0;
    chk("start_cmd_rst", 32'(cmd_to_root), 32'(RSTC));
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_fill_clr", 32'(fill_count), 32'd0);
    chk("start_err_clr", 32'(err_code), 32'd0);
  endtask

  // Root answers rst_done on the third edge after start.
  task automatic rst_phase();
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_hold", 32'(cmd_to_root), 32'(RSTC));
    end
    cmd_from_root = RST_DONE;
    tick();
    cmd_from_root = NOP;
    chk("fill_entry_nop", 32'(cmd_to_root), 32'(NOP));
    chk("fill_entry_busy", 32'(busy), 32'd1);
  endtask

  task automatic beat(input logic [23:0] v, input int exp_cnt);
    center_valid = 1'b1;
    center_data = v;
    chk("beat_ready", 32'(center_ready), 32'd1);
    tick();
    center_valid = 1'b0;
    center_data = '0;
    chk("beat_cmd", 32'(cmd_to_root), 32'(FILL));
    chk("beat_data", 32'(data_to_root), 32'(v));
    chk("beat_count", 32'(fill_count), 32'(exp_cnt));
  endtask

  task automatic finish_fill_and_axis(input logic [1:0] axis);
    chk("full_ready_low", 32'(center_ready), 32'd0);
    tick();
    chk("zero_fill_cmd", 32'(cmd_to_root), 32'(FILL));
    chk("zero_fill_data", 32'(data_to_root), 32'd0);
    cmd_from_root = FILL_DONE;
    tick();
    cmd_from_root = NOP;
    chk("axis_cmd", 32'(cmd_to_root), 32'(AXIS));
    chk("axis_data", 32'(data_to_root), 32'(axis));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("axis_hold", 32'(cmd_to_root), 32'(AXIS));
    end
    cmd_from_root = AXIS_DONE;
    tick();
    cmd_from_root = NOP;
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_cmd_nop", 32'(cmd_to_root), 32'(NOP));
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_fill", 32'(fill_count), 32'd7);
    tick();
    chk("done_single", 32'(done), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sort_axis = 2'd0;
    center_valid = 1'b0; center_data = '0; cmd_from_root = NOP;
    repeat (2) tick();
    chk("rst_cmd", 32'(cmd_to_root), 32'(NOP));
    chk("rst_data", 32'(data_to_root), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_errcode", 32'(err_code), 32'd0);
    chk("rst_fill", 32'(fill_count), 32'd0);
    chk("rst_ready", 32'(center_ready), 32'd0);
    rst = 1'b0;
    tick();

    // Normal run, axis 2, centers 1..7
    do_start(2'd2);
    rst_phase();
    for (int i = 1; i <= 7; i++) beat(24'(i), i);
    finish_fill_and_axis(2'd2);
    $display("[TB] normal run complete");

    // Five-cycle source stall after beat 3, with a stray axis_done injected
    do_start(2'd1);
    rst_phase();
    for (int i = 1; i <= 3; i++) beat(24'(32'h10 + i), i);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) cmd_from_root = AXIS_DONE;
      tick();
      cmd_from_root = NOP;
      chk("stall_nop", 32'(cmd_to_root), 32'(NOP));
      chk("stall_count", 32'(fill_count), 32'd3);
      chk("stall_busy", 32'(busy), 32'd1);
    end
    for (int i = 4; i <= 7; i++) beat(24'(32'h10 + i), i);
    finish_fill_and_axis(2'd1);
    $display("[TB] stalled run complete");

    // Root reports fill done after only 4 beats
    do_start(2'd3);
    rst_phase();
    for (int i = 1; i <= 4; i++) beat(24'(i), i);
    cmd_from_root = FILL_DONE;
    tick();
    cmd_from_root = NOP;
    chk("short_error", 32'(error), 32'd1);
    chk("short_code", 32'(err_code), 32'd1);
    chk("short_cmd", 32'(cmd_to_root), 32'(NOP));
    chk("short_busy", 32'(busy), 32'd0);
    tick();
    chk("short_error_hold", 32'(error), 32'd1);
    $display("[TB] short fill run complete");

    // Asynchronous reset during FILL after 2 beats, then restart
    do_start(2'd0);
    chk("restart_error_clr", 32'(error), 32'd0);
    rst_phase();
    for (int i = 1; i <= 2; i++) beat(24'(i), i);
    #2 rst = 1'b1;
    #1;
    chk("arst_cmd", 32'(cmd_to_root), 32'(NOP));
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_fill", 32'(fill_count), 32'd0);
    chk("arst_ready", 32'(center_ready), 32'd0);
    #2 rst = 1'b0;
    tick();
    do_start(2'd2);
    $display("[TB] async reset run complete");

    // Root never answers rst
`ifdef KD_ROOT_CTRL_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("tmo_pre_cmd", 32'(cmd_to_root), 32'(RSTC));
      chk("tmo_pre_err", 32'(error), 32'd0);
    end
    tick();
    chk("tmo_error", 32'(error), 32'd1);
    chk("tmo_code", 32'(err_code), 32'd2);
    chk("tmo_cmd", 32'(cmd_to_root), 32'(NOP));
`else
    repeat (100) tick();
    chk("notmo_cmd", 32'(cmd_to_root), 32'(RSTC));
    chk("notmo_busy", 32'(busy), 32'd1);
    chk("notmo_code", 32'(err_code), 32'd0);
`endif
    $display("[TB] silent root run complete");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/kd_tree_root_ctrl.md
# kd_tree_root_ctrl

Sequencer that sits directly above the kd-tree root node and drives its top-side command/data port. On `start` it runs the tree bring-up sequence: reset propagation, center fill from an upstream center stream, then sort-axis configuration. It waits for each phase's completion command from the root, then reports done or error to the host-side logic. It supplies the tree's only top-level stimulus and consumes the root's upward responses.

## Interface
Parameters:
- `DATA_W`, 24: data word width (one packed center).
- `CMD_W`, 5: command width.
- `NUM_CENTERS`, 7: number of centers streamed; equals tree node count.
- `CNT_W`, 4: width of the center counter; must hold `NUM_CENTERS`.
- `TIMEOUT`, 1023: per-phase watchdog limit in cycles (used only with the macro).

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin sequence; sampled in IDLE, DONE and ERR only.
- `sort_axis` in 2: axis to configure; captured on accepted `start`.
- `center_data` in DATA_W: next center from the source.
- `center_valid` in 1: `center_data` is valid.
- `center_ready` out 1: controller takes `center_data` this cycle.
- `cmd_to_root` out CMD_W: connects to the root's `command_from_top`.
- `data_to_root` out DATA_W: connects to the root's `data_from_top`.
- `cmd_from_root` in CMD_W: connects to the root's `command_to_top`.
- `busy` out 1: high in every state except IDLE, DONE and ERR.
- `done` out 1: one-cycle pulse on entry to DONE.
- `error` out 1: high while in ERR.
- `err_code` out 2: 0 none, 1 fill short, 2 timeout; holds until the next accepted `start`.
- `fill_count` out CNT_W: centers issued in the current or last sequence.

## Operation
- Command codes: nop 00000, rst 11111, rst_done 11110, center_fill 00001, center_fill_done 00101, configure_sort_axis 00010, configure_sort_axis_done 00111.
- States: IDLE, RST, FILL, AXIS, DONE, ERR.
- IDLE/DONE/ERR: drive nop with data 0. `start` moves to RST, clears `fill_count` and `err_code`, and latches `sort_axis`.
- RST: drive rst with data 0 every cycle. When `cmd_from_root`==rst_done, go to FILL.
- FILL:
  - `center_ready` = (state==FILL) && (`fill_count` < NUM_CENTERS), combinational.
  - On a handshake (`center_valid` && `center_ready`): next `cmd_to_root`=center_fill, `data_to_root`=`center_data`, and `fill_count` increments.
  - When the counter is below NUM_CENTERS and there is no valid beat: drive nop, which pauses the tree.
  - Once `fill_count`==NUM_CENTERS: drive center_fill with data 0 every cycle until the root answers.
  - `cmd_from_root`==center_fill_done moves to AXIS. If `fill_count`<NUM_CENTERS at that point, go to ERR with code 1 instead.
- AXIS: drive configure_sort_axis with `data_to_root` = {zeros, latched axis}. `cmd_from_root`==configure_sort_axis_done moves to DONE and pulses `done`.
- Expected completion codes arriving in other states are ignored.
- A done code for a later phase arriving early is ignored.
- `start` while busy is ignored.

## Timing
- All outputs registered except `center_ready`. Reset values: `cmd_to_root`=nop, `data_to_root`=0, `busy`=0, `done`=0, `error`=0, `err_code`=0, `fill_count`=0, state IDLE.
- `start` at edge N: rst appears on `cmd_to_root` after edge N.
- Completion code sampled at edge M: the next phase's command appears after edge M. The old command is never driven after M.
- A center beat accepted at edge N appears on `data_to_root` after edge N, for exactly one cycle.
- Asserting `rst` mid-sequence returns to IDLE immediately, with outputs at reset values. Centers already issued are lost, and the source is not rewound.
- A completion code and a timeout in the same cycle: completion wins.

## Configuration
- `KD_ROOT_CTRL_TIMEOUT_EN` defined:
  - A phase counter clears on entry to RST, FILL and AXIS, and increments every cycle in those states.
  - FILL pauses also count.
  - When the counter reaches TIMEOUT without the expected completion code: go to ERR with code 2 and drive nop.
- Undefined: no counter, no timeout path. The controller waits indefinitely and `err_code` never equals 2.

## Test plan
- Normal run, NUM_CENTERS=7, axis=2, root model returns rst_done after 3 cycles, center_fill_done 2 cycles after the 7th beat, and axis_done after 4 cycles:
  - Command order: rst, then 7×center_fill carrying data 0x000001…0x000007, then zero-data center_fill, then configure_sort_axis with data 0x000002.
  - `done` pulses once; `fill_count`=7.
- Source deasserts `center_valid` for 5 cycles after beat 3:
  - nop is driven for those 5 cycles, `fill_count` stays at 3, and the sequence then completes normally.
- Root returns center_fill_done after 4 beats: ERR, `err_code`=1, `error`=1, `cmd_to_root`=nop.
- Macro defined with TIMEOUT=16 and a root that never sends rst_done: ERR on cycle 16 of RST with `err_code`=2. Macro undefined: still in RST after 100 cycles.
- `rst` asserted during FILL after 2 beats: the same cycle shows nop, `busy`=0 and `fill_count`=0. A new `start` restarts from RST.
- configure_sort_axis_done injected during FILL: ignored, and FILL continues.
